// File: rtl/chaser_input_ctrl_if.sv
// Button/control bundle between the board push-buttons and the chaser.
//   btn_en, btn_dir, btn_rst : raw asynchronous buttons, active-high
//   en_out, dir_out          : toggled control levels to the chaser
//   rst_out                  : stretched reset to the chaser
//   press[2:0]               : one-cycle debounced press pulses {rst, dir, en}
// The master modport drives the buttons; the slave modport is the conditioner.
interface chaser_input_ctrl_if;
    logic       btn_en;
    logic       btn_dir;
    logic       btn_rst;
    logic       en_out;
    logic       dir_out;
    logic       rst_out;
    logic [2:0] press;

    modport master (
        output btn_en, btn_dir, btn_rst,
        input  en_out, dir_out, rst_out, press
    );

    modport slave (
        input  btn_en, btn_dir, btn_rst,
        output en_out, dir_out, rst_out, press
    );
endinterface

// File: rtl/chaser_input_ctrl.sv
// Input conditioner for the two-LED chaser. Each of the three raw buttons is
// synchronized (2 FFs), debounced with a saturating agreement counter and turned
// into a one-cycle press pulse. Enable/direction presses toggle level outputs;
// a reset press clears them and (re)starts a stretched reset that is long enough
// for the chaser's slow divided-clock domains to observe.
// Ports:
//   clk : board clock
//   rst : synchronous active-high reset
//   bus : chaser_input_ctrl_if.slave (buttons in; en_out, dir_out, rst_out, press out)
module chaser_input_ctrl #(
    parameter int unsigned DB_W     = 20,
    parameter int unsigned DB_MAX   = 999999,
    parameter int unsigned HOLD_W   = 27,
    parameter int unsigned HOLD_CYC = 67108864
) (
    input  logic                clk,
    input  logic                rst,
    chaser_input_ctrl_if.slave  bus
);

    localparam logic [DB_W-1:0]   DbMax   = DB_W'(DB_MAX);
    localparam logic [HOLD_W-1:0] HoldCyc = HOLD_W'(HOLD_CYC);

    // Channel order: 0 enable, 1 direction, 2 reset.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      db_q;
    logic [2:0]      db_d;
    logic [DB_W-1:0] cnt_q [3];
    logic [DB_W-1:0] cnt_d [3];
    logic [2:0]      press_q;
    logic [2:0]      press_d;

    logic              en_q;
    logic              en_d;
    logic              dir_q;
    logic              dir_d;
    logic [HOLD_W-1:0] hc_q;
    logic [HOLD_W-1:0] hc_d;

    assign btn_raw = {bus.btn_rst, bus.btn_dir, bus.btn_en};

    // Debounce: the counter only runs while the synchronized level disagrees with
    // the debounced state, so any bounce back clears it.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DbMax) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
        // Rising debounced edge only; releases do not pulse.
        press_d = db_d & ~db_q;
    end

    always_comb begin
        en_d  = en_q;
        dir_d = dir_q;
        hc_d  = hc_q;
        // A reset press takes priority over simultaneous toggles.
        if (press_q[2]) begin
            en_d  = 1'b0;
            dir_d = 1'b0;
        end else begin
            if (press_q[0]) en_d  = ~en_q;
            if (press_q[1]) dir_d = ~dir_q;
        end
        if (press_q[2]) begin
            hc_d = HoldCyc;
        end else if (hc_q != '0) begin
            hc_d = hc_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            en_q    <= 1'b0;
            dir_q   <= 1'b0;
            hc_q    <= HoldCyc;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            en_q    <= en_d;
            dir_q   <= dir_d;
            hc_q    <= hc_d;
        end
    end

    assign bus.en_out  = en_q;
    assign bus.dir_out = dir_q;
    assign bus.rst_out = (hc_q != '0);
    assign bus.press   = press_q;

endmodule

// File: tb/tb_chaser_input_ctrl.sv
// Directed bench for chaser_input_ctrl with DB_MAX=4, HOLD_CYC=8.
module tb_chaser_input_ctrl;

    logic clk = 1'b0;
    logic rst;

    chaser_input_ctrl_if bus ();

    chaser_input_ctrl #(
        .DB_W    (20),
        .DB_MAX  (4),
        .HOLD_W  (27),
        .HOLD_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       dir;
        logic       rb;
        int         n;
        logic       exp_en;
        logic       exp_dir;
        logic       exp_ro;
        logic [2:0] exp_press;
    } vec_t;

    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic void add(logic en, logic dir, logic rb, int n,
                                logic e_en, logic e_dir, logic e_ro, logic [2:0] e_pr);
        vec_t v;
        v.en = en; v.dir = dir; v.rb = rb; v.n = n;
        v.exp_en = e_en; v.exp_dir = e_dir; v.exp_ro = e_ro; v.exp_press = e_pr;
        tbl.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(logic en, logic dir, logic rb);
        bus.btn_en  = en;
        bus.btn_dir = dir;
        bus.btn_rst = rb;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // 1. Reset and stretch after release.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rst_out", 32'(bus.rst_out), 32'd1);
            chk("rst_en", 32'(bus.en_out), 32'd0);
            chk("rst_dir", 32'(bus.dir_out), 32'd0);
            chk("rst_press", 32'(bus.press), 32'd0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("rst_stretch_hi", 32'(bus.rst_out), 32'd1);
        end
        tick();
        chk("rst_stretch_lo", 32'(bus.rst_out), 32'd0);

        // 2. Two clean enable presses.
        add(1, 0, 0, 6, 0, 0, 0, 3'b000);
        add(1, 0, 0, 1, 0, 0, 0, 3'b001);
        add(1, 0, 0, 1, 1, 0, 0, 3'b000);
        add(1, 0, 0, 12, 1, 0, 0, 3'b000);
        add(0, 0, 0, 12, 1, 0, 0, 3'b000);
        add(1, 0, 0, 6, 1, 0, 0, 3'b000);
        add(1, 0, 0, 1, 1, 0, 0, 3'b001);
        add(1, 0, 0, 1, 0, 0, 0, 3'b000);
        add(0, 0, 0, 12, 0, 0, 0, 3'b000);
        // 3. Bouncing enable, then steady high.
        for (int i = 0; i < 5; i++) begin
            add(1, 0, 0, 3, 0, 0, 0, 3'b000);
            add(0, 0, 0, 3, 0, 0, 0, 3'b000);
        end
        add(1, 0, 0, 6, 0, 0, 0, 3'b000);
        add(1, 0, 0, 1, 0, 0, 0, 3'b001);
        add(1, 0, 0, 1, 1, 0, 0, 3'b000);
        add(1, 0, 0, 5, 1, 0, 0, 3'b000);
        add(0, 0, 0, 12, 1, 0, 0, 3'b000);
        // 4. Direction press, then reset press clears both levels and stretches.
        add(0, 1, 0, 6, 1, 0, 0, 3'b000);
        add(0, 1, 0, 1, 1, 0, 0, 3'b010);
        add(0, 1, 0, 1, 1, 1, 0, 3'b000);
        add(0, 0, 0, 12, 1, 1, 0, 3'b000);
        add(0, 0, 1, 6, 1, 1, 0, 3'b000);
        add(0, 0, 1, 1, 1, 1, 0, 3'b100);
        add(0, 0, 1, 1, 0, 0, 1, 3'b000);
        add(0, 0, 1, 7, 0, 0, 1, 3'b000);
        add(0, 0, 1, 1, 0, 0, 0, 3'b000);
        add(0, 0, 0, 12, 0, 0, 0, 3'b000);
        // Simultaneous enable and reset press: reset wins, en_out stays 0.
        add(1, 0, 1, 6, 0, 0, 0, 3'b000);
        add(1, 0, 1, 1, 0, 0, 0, 3'b101);
        add(1, 0, 1, 1, 0, 0, 1, 3'b000);
        add(1, 0, 1, 7, 0, 0, 1, 3'b000);
        add(1, 0, 1, 1, 0, 0, 0, 3'b000);
        add(0, 0, 0, 12, 0, 0, 0, 3'b000);

        foreach (tbl[v]) begin
            drive(tbl[v].en, tbl[v].dir, tbl[v].rb);
            for (int j = 0; j < tbl[v].n; j++) begin
                tick();
                if (j < tbl[v].n - 1) begin
                    chk($sformatf("vec%0d_press_mid", v), 32'(bus.press), 32'd0);
                end else begin
                    chk($sformatf("vec%0d_press", v), 32'(bus.press), 32'(tbl[v].exp_press));
                    chk($sformatf("vec%0d_en", v), 32'(bus.en_out), 32'(tbl[v].exp_en));
                    chk($sformatf("vec%0d_dir", v), 32'(bus.dir_out), 32'(tbl[v].exp_dir));
                    chk($sformatf("vec%0d_rst_out", v), 32'(bus.rst_out), 32'(tbl[v].exp_ro));
                end
            end
        end

        // 5. Retrigger: rst at hc=3, then the still-held button presses again at hc=1.
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rt_press_wait", 32'(bus.press), 32'd0);
        end
        tick();
        chk("rt_press1", 32'(bus.press), 32'd4);
        tick();
        chk("rt_load1", 32'(bus.rst_out), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rt_hold1", 32'(bus.rst_out), 32'd1);
        end
        rst = 1'b1;
        tick();
        chk("rt_rst_hi", 32'(bus.rst_out), 32'd1);
        chk("rt_rst_press", 32'(bus.press), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rt_hold2", 32'(bus.rst_out), 32'd1);
            chk("rt_press_wait2", 32'(bus.press), 32'd0);
        end
        tick();
        chk("rt_press2", 32'(bus.press), 32'd4);
        chk("rt_hold_hc1", 32'(bus.rst_out), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rt_hold3", 32'(bus.rst_out), 32'd1);
        end
        tick();
        chk("rt_drop", 32'(bus.rst_out), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rt_release_press", 32'(bus.press), 32'd0);
        end

        // 6. rst mid-debounce (cnt=3) discards the count; held button re-presses.
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("md_press_pre", 32'(bus.press), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("md_press_rst", 32'(bus.press), 32'd0);
            chk("md_dir_rst", 32'(bus.dir_out), 32'd0);
            chk("md_rst_out", 32'(bus.rst_out), 32'd1);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("md_press_wait", 32'(bus.press), 32'd0);
            chk("md_dir_wait", 32'(bus.dir_out), 32'd0);
        end
        tick();
        chk("md_press", 32'(bus.press), 32'd2);
        chk("md_dir_pre", 32'(bus.dir_out), 32'd0);
        tick();
        chk("md_dir", 32'(bus.dir_out), 32'd1);
        chk("md_press_end", 32'(bus.press), 32'd0);
        chk("md_rst_out_end", 32'(bus.rst_out), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
